// File: rtl/ysyx_25060166_mdu_if.sv
// Request/response channel between EXU and the multiply/divide unit.
//   in_valid/in_ready : request handshake carrying in_op, in_a, in_b
//   out_valid/out_ready : response handshake carrying out_result
//   busy : unit is working on or holding a result
interface ysyx_25060166_mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             busy;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/ysyx_25060166_mdu.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add multiply,
// restoring divide). One operation in flight; EXU stalls on it.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : request in_valid/in_ready/in_op/in_a/in_b,
//                  response out_valid/out_ready/out_result, busy
module ysyx_25060166_mdu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    ysyx_25060166_mdu_if.slave   bus
);

    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    // mul: running product; div: {remainder, dividend->quotient}
    logic [W2-1:0]      acc_q, acc_d;
    // mul: sign-extended multiplicand shifted left each step; div: divisor in low half
    logic [W2-1:0]      mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_result_q, out_result_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    // Request decode
    logic               req_div, req_div_signed, req_a_signed;
    logic               a_neg, b_neg, div_zero, div_ovf;
    logic [WIDTH-1:0]   a_mag, b_mag;

    // Iteration datapath
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               last_iter;

    // Result fix-up
    logic [WIDTH-1:0]   quot, rem, quot_fix, rem_fix, final_res;

    always_comb begin
        req_div        = bus.in_op[2];
        req_div_signed = req_div & ~bus.in_op[0];
        req_a_signed   = (bus.in_op == 3'b001) | (bus.in_op == 3'b010);
        a_neg          = bus.in_a[WIDTH-1];
        b_neg          = bus.in_b[WIDTH-1];
        a_mag          = (req_div_signed & a_neg) ? WIDTH'(0) - bus.in_a : bus.in_a;
        b_mag          = (req_div_signed & b_neg) ? WIDTH'(0) - bus.in_b : bus.in_b;
        div_zero       = req_div & (bus.in_b == '0);
        div_ovf        = req_div_signed & (bus.in_a == {1'b1, {(WIDTH-1){1'b0}}})
                         & (&bus.in_b);
    end

    always_comb begin
        rem_sh    = acc_q[W2-1:WIDTH-1];
        rem_diff  = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Final result: high/low product half, or sign-corrected quotient/remainder
    always_comb begin
        quot     = acc_q[WIDTH-1:0];
        rem      = acc_q[W2-1:WIDTH];
        quot_fix = q_neg_q ? WIDTH'(0) - quot : quot;
        rem_fix  = r_neg_q ? WIDTH'(0) - rem : rem;
        if (op_q[2]) begin
            final_res = op_q[1] ? rem_fix : quot_fix;
        end else begin
            final_res = (op_q[1:0] == 2'b00) ? acc_q[WIDTH-1:0] : acc_q[W2-1:WIDTH];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d    = bus.in_op;
                    cnt_d   = '0;
                    q_neg_d = 1'b0;
                    r_neg_d = 1'b0;
                    if (!req_div) begin
                        mcand_d  = req_a_signed ? {{WIDTH{a_neg}}, bus.in_a}
                                                : {{WIDTH{1'b0}}, bus.in_a};
                        mplier_d = bus.in_b;
                        acc_d    = '0;
                        state_d  = S_CALC;
                    end else if (div_zero) begin
                        // quotient all ones, remainder is the raw dividend
                        acc_d   = {bus.in_a, {WIDTH{1'b1}}};
                        state_d = S_DONE;
                    end else if (div_ovf) begin
                        acc_d   = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
                        state_d = S_DONE;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
                        mcand_d = {{WIDTH{1'b0}}, b_mag};
                        q_neg_d = req_div_signed & (a_neg ^ b_neg);
                        r_neg_d = req_div_signed & a_neg;
                        state_d = S_CALC;
                    end
                end
            end

            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[2]) begin
                    // Restoring step: keep the subtraction only if it did not borrow
                    if (!rem_diff[WIDTH]) begin
                        acc_d = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    // MULH treats rs2 bit WIDTH-1 as weight -2^(WIDTH-1)
                    if (mplier_q[0]) begin
                        if (last_iter && (op_q == 3'b001)) begin
                            acc_d = acc_q - mcand_q;
                        end else begin
                            acc_d = acc_q + mcand_q;
                        end
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if (last_iter) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d  = 1'b1;
                    out_result_d = final_res;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            acc_q        <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ysyx_25060166_mdu.sv
// Self-checking bench for ysyx_25060166_mdu: vector table with a
// result scoreboard, latency checks, backpressure and mid-op reset.
module tb_ysyx_25060166_mdu;

    localparam int unsigned WIDTH = 32;
    localparam int          LAT_N = 33;
    localparam int          LAT_S = 1;
    localparam int          BOUND = 100;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NVEC = 20;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    logic [31:0] sb[$];
    vec_t vecs[NVEC];

    ysyx_25060166_mdu_if #(.WIDTH(WIDTH)) bus ();

    ysyx_25060166_mdu #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one request; accepted at the next edge. Inputs are scrambled afterwards.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int waited;
        waited = 0;
        while (!bus.in_ready && waited < BOUND) begin
            tick();
            waited++;
        end
        if (waited >= BOUND) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
        bus.in_valid = 1'b0;
        bus.in_op    = 3'($urandom);
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!bus.out_valid && cyc < BOUND) begin
            tick();
            cyc++;
        end
    endtask

    // Compare the produced result against the scoreboard head
    task automatic collect(input string name, input int lat);
        int          cyc;
        logic [31:0] exp;
        wait_out(cyc);
        check({name, "_latency"}, 32'(cyc), 32'(lat));
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            exp = sb.pop_front();
            check({name, "_result"}, bus.out_result, exp);
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_N};
        vecs[1]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_N};
        vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_N};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, LAT_N};
        vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, LAT_N};
        vecs[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, LAT_N};
        vecs[6]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14,        LAT_N};
        vecs[7]  = '{OP_REMU,   32'd100,       32'd7,         32'd2,         LAT_N};
        vecs[8]  = '{OP_DIVU,   32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, LAT_S};
        vecs[9]  = '{OP_REMU,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, LAT_S};
        vecs[10] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_S};
        vecs[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_S};
        vecs[12] = '{OP_DIV,    32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, LAT_S};
        vecs[13] = '{OP_REM,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, LAT_S};
        vecs[14] = '{OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_N};
        vecs[15] = '{OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, LAT_N};
        vecs[16] = '{OP_DIV,    32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, LAT_N};
        vecs[17] = '{OP_MUL,    32'h0001_0000, 32'h0001_0000, 32'h0000_0000, LAT_N};
        vecs[18] = '{OP_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h0000_0001, LAT_N};
        vecs[19] = '{OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_N};

        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        repeat (3) tick();

        check("rst_out_valid",  32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result,     32'd0);
        check("rst_in_ready",   32'(bus.in_ready),  32'd1);
        check("rst_busy",       32'(bus.busy),      32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            sb.push_back(vecs[i].exp);
            collect($sformatf("vec%0d", i), vecs[i].lat);
            take();
            check($sformatf("vec%0d_in_ready_after", i), 32'(bus.in_ready), 32'd1);
        end

        // Backpressure: result and status held while out_ready is low
        issue(OP_DIVU, 32'd100, 32'd7);
        sb.push_back(32'd14);
        collect("bp", LAT_N);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_hold%0d_valid", k),  32'(bus.out_valid), 32'd1);
            check($sformatf("bp_hold%0d_result", k), bus.out_result,     32'd14);
            check($sformatf("bp_hold%0d_ready", k),  32'(bus.in_ready),  32'd0);
            check($sformatf("bp_hold%0d_busy", k),   32'(bus.busy),      32'd1);
        end
        take();
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready),  32'd1);
        check("bp_release_busy",  32'(bus.busy),      32'd0);

        // Reset during the 10th CALC cycle aborts the op with no response
        issue(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) tick();
        check("mid_busy_before_reset", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_rst_busy",      32'(bus.busy),      32'd0);
        issue(OP_MUL, 32'd3, 32'd5);
        sb.push_back(32'd15);
        collect("post_rst_mul", LAT_N);
        take();

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25060166_mdu.md
Name: ysyx_25060166_mdu

Overview:
Iterative multi-cycle multiply/divide unit for the RV32 M-extension. It sits beside the single-cycle combinational ALU in the EXU stage.
- Accepts an operand pair and a funct3 op from the execute stage over a valid/ready request channel.
- Returns the 32-bit result over a valid/ready response channel.
- The ALU is the combinational path; this block is the sequential responder that EXU stalls on.

Parameters:
WIDTH, 32, operand/result width in bits (RV32).
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  request valid.
in_ready  output  1  unit can accept a request.
in_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
in_a  input  WIDTH  rs1 operand.
in_b  input  WIDTH  rs2 operand.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_result  output  WIDTH  result.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counter=0, out_valid=0, out_result=0, busy=0, in_ready=1. Reset mid-operation aborts the operation; no response is ever produced for it.
- States: IDLE, CALC, DONE.
  - IDLE -> CALC on in_valid&in_ready for a normal op.
  - IDLE -> DONE directly for a special-case op.
  - CALC -> DONE when counter reaches WIDTH-1.
  - DONE -> IDLE on out_ready.
- in_ready = (state==IDLE). Operands and op are latched on acceptance; input changes afterwards are ignored.
- Latency, with acceptance at edge T:
  - Normal ops: CALC occupies WIDTH cycles; out_valid rises after edge T+WIDTH+1 (33 cycles for WIDTH=32).
  - Special cases: out_valid rises after edge T+1.
- out_valid/out_result are registered and held stable until out_ready is high on a clock edge. No new request is accepted in the cycle the result is taken; in_ready returns the cycle after. Back-to-back issue is therefore one bubble minimum.
- Multiply: radix-2 shift-add over a 2*WIDTH product.
  - Operands are sign-extended per op: MULH both signed; MULHSU a signed, b unsigned; MUL and MULHU unsigned.
  - MUL returns product[WIDTH-1:0]. MULH, MULHSU and MULHU return product[2*WIDTH-1:WIDTH].
- Divide: restoring division on magnitudes.
  - Signed ops take absolute values at acceptance and fix signs at DONE entry.
  - Quotient is negated if signs differ; remainder takes the dividend's sign.
- Special cases (no CALC):
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return in_a.
  - Signed overflow (in_a=0x80000000, in_b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
  - Multiply has no special cases.
- busy=1 in CALC and DONE.
- in_valid while busy: no effect; the request is held off by in_ready=0.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> out_result=0xFFFFFFEB; out_valid first seen 33 cycles after acceptance.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU a=0x1234, b=0 -> 0xFFFFFFFF. REMU same operands -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. All four with out_valid the cycle after acceptance.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_result stable, in_ready=0, busy=1; raise out_ready -> next cycle out_valid=0, in_ready=1.
- Assert reset in the 10th CALC cycle -> next cycle state IDLE, out_valid=0, in_ready=1; the following MUL 3*5 returns 15 with normal latency.
